reg_status_file: RTL
====================

Name: reg_status_file

Overview:
- Architectural register file with per-register rename status (busy bit plus ROB tag) for the Tomasulo RV32I core.
- Sits between the instruction-queue issue logic and the ROB. Issue reads operand values and renames destinations; the ROB commit path writes retired values and releases busy status.
- Flushes all rename state on a mispredict clear.
- Supplies the ROB with the current busy/tag of the register being committed.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (index width 5)
TAG_W, 4, ROB tag width (ROB depth 2**TAG_W)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
rdy  input  1  global ready; when low all state holds
clear_flag  input  1  mispredict flush from the ROB, registered by the top level
rs1  input  5  issue read index 1
rs2  input  5  issue read index 2
rs1_value  output  XLEN  register value at rs1
rs1_busy  output  1  rs1 awaiting an in-flight producer
rs1_tag  output  TAG_W  ROB tag of the rs1 producer
rs2_value  output  XLEN  register value at rs2
rs2_busy  output  1  rs2 awaiting an in-flight producer
rs2_tag  output  TAG_W  ROB tag of the rs2 producer
rename_valid  input  1  issue allocates a destination this cycle
rename_rd  input  5  destination register
rename_tag  input  TAG_W  ROB slot allocated to it
commit_valid  input  1  ROB retires a register write
commit_rd  input  5  retired destination
commit_value  input  XLEN  retired value
commit_clear_busy  input  1  ROB has confirmed the tag match; release busy
commit_busy  output  1  busy bit of commit_rd (combinational)
commit_tag  output  TAG_W  tag of commit_rd (combinational)
retired_count  output  32  number of accepted commit writes, debug/perf

Behaviour:
- Storage: value[NREG], busy[NREG], tag[NREG].
- Reset: all value 0, busy 0, tag 0, retired_count 0. All outputs therefore read 0 in the cycle after reset.
- Reset has priority over everything. Reset mid-stream discards pending renames.
- rdy low with rst low: no state change. Combinational outputs still track inputs.
- Reads (rs1/rs2/commit_rd ports):
  - Purely combinational from current state; no same-cycle bypass of commit_value or rename.
  - The issue stage resolves a same-cycle result through the ROB ready/value lookup.
  - Index 0 always reads value 0, busy 0, tag 0, regardless of stored state.
- Commit (rdy=1):
  - commit_valid and commit_rd!=0: value[commit_rd] <= commit_value.
  - retired_count increments on every commit_valid, including rd=0; it wraps at 2**32.
  - commit_clear_busy and commit_rd!=0: busy[commit_rd] <= 0. The tag is left unchanged.
  - commit_clear_busy without commit_valid is ignored.
- Rename (rdy=1, clear_flag=0):
  - rename_valid and rename_rd!=0: busy[rename_rd] <= 1, tag[rename_rd] <= rename_tag.
  - Writes to x0 are dropped.
- Same-cycle commit and rename of the same register: the value is written, and rename wins the status (busy=1, tag=rename_tag).
- Rename of a register that is already busy overwrites the tag; the newest producer wins.
- clear_flag=1 (rdy=1):
  - All busy <= 0 and the rename input is ignored.
  - The commit write in the same cycle still updates value and retired_count, because a JALR commit and the flush coincide.
  - Tags are not cleared.
- Latency: an update is visible on the read ports in the cycle after the posedge that captured it.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> both value 0, busy 0, tag 0; retired_count=0.
- Rename x5 tag 3; next cycle commit x5=0xDEADBEEF with clear_busy -> after rename rs1=5 reads busy 1, tag 3; after commit value 0xDEADBEEF, busy 0, retired_count=1.
- Same cycle: commit x7=0x11 with clear_busy and rename x7 tag 9 -> x7 value 0x11, busy 1, tag 9.
- Rename x1 tag 2 and x2 tag 4, then clear_flag plus commit x3=0x55 plus rename x4 tag 6 in the same cycle -> x1, x2, x4 all busy 0; x3=0x55; x4 not renamed.
- Rename x0 tag 5 and commit x0=0xFFFF -> x0 reads 0/0/0; retired_count increments by 1.
- rdy=0 held for 3 cycles while commit x9=0x77 and rename x10 tag 1 are asserted -> no state change; retired_count unchanged; commit_busy/commit_tag still follow commit_rd.

Source files
------------

// File: rtl/reg_status_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_status_file
// Brief    : Architectural register file with per-register rename status
//            (busy bit + ROB tag) for the Tomasulo RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
module reg_status_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear_flag,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [XLEN-1:0]  rs1_value,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_value,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic             rename_valid,
    input  logic [4:0]       rename_rd,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [XLEN-1:0]  commit_value,
    input  logic             commit_clear_busy,
    output logic             commit_busy,
    output logic [TAG_W-1:0] commit_tag,
    output logic [31:0]      retired_count
);

    logic [XLEN-1:0]  r_value [NREG];
    logic [TAG_W-1:0] r_tag   [NREG];
    logic [NREG-1:0]  r_busy;
    logic [31:0]      r_retired_count;

    logic w_commit_wr;
    logic w_commit_rel;
    logic w_rename_wr;

    assign w_commit_wr  = commit_valid && (commit_rd != 5'd0);
    assign w_commit_rel = w_commit_wr && commit_clear_busy;
    assign w_rename_wr  = rename_valid && !clear_flag && (rename_rd != 5'd0);

    // Rename is applied after commit so it wins the status on a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy          <= '0;
            r_retired_count <= '0;
        end else if (rdy) begin
            if (commit_valid) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
            if (w_commit_wr) begin
                r_value[commit_rd] <= commit_value;
            end
            if (w_commit_rel) begin
                r_busy[commit_rd] <= 1'b0;
            end
            if (clear_flag) begin
                r_busy <= '0;
            end else if (w_rename_wr) begin
                r_busy[rename_rd] <= 1'b1;
                r_tag[rename_rd]  <= rename_tag;
            end
        end
    end

    // x0 is hard-wired to zero/idle regardless of what storage holds.
    always_comb begin
        rs1_value   = '0;
        rs1_busy    = 1'b0;
        rs1_tag     = '0;
        rs2_value   = '0;
        rs2_busy    = 1'b0;
        rs2_tag     = '0;
        commit_busy = 1'b0;
        commit_tag  = '0;
        if (rs1 != 5'd0) begin
            rs1_value = r_value[rs1];
            rs1_busy  = r_busy[rs1];
            rs1_tag   = r_tag[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_value = r_value[rs2];
            rs2_busy  = r_busy[rs2];
            rs2_tag   = r_tag[rs2];
        end
        if (commit_rd != 5'd0) begin
            commit_busy = r_busy[commit_rd];
            commit_tag  = r_tag[commit_rd];
        end
    end

    assign retired_count = r_retired_count;

endmodule
`default_nettype wire
